decoder_rr_arbiter: RTL

//  Round-robin arbiter that shares a 16-way active-low one-hot select bus (same encoding
//  as the 4-to-16 decoder: exactly one output low, rest high) between 16 requesters.

---
 rtl/decoder_rr_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
// Round-robin arbiter that shares a 16-way active-low one-hot select bus between
// 16 requesters. It picks an owner, drives its select line low, holds it until the
// owner releases it, then forces an all-high gap before the next arbitration.
// Optional feature: define ARB_TIMEOUT_EN to bound every grant to MAX_HOLD cycles
// and pulse 'timeout' on the forced release. Without it, 'timeout' is tied low.
module decoder_rr_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt_n,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_gap_range
    $error("decoder_rr_arbiter: GAP_CYCLES must be in 1..15");
  end

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_hold_range
    $error("decoder_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ptr;
  logic [3:0]  gap_cnt;
  logic [3:0]  pick_idx;
  logic        pick_found;
  logic        rel_normal;
  logic        rel_force;
  logic        release_now;
  logic [15:0] gnt_n_nxt;
  logic [3:0]  gnt_idx_nxt;
  logic        gnt_valid_nxt;

  // Rotating priority search: the lowest offset from ptr that is requesting wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int k = 15; k >= 0; k--) begin
      if (req[ptr + 4'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + 4'(k);
      end
    end
  end

  // The owner gives up the bus on done, on dropping its request, or on disable
  always_comb begin
    rel_normal  = done | ~req[gnt_idx] | en_n;
    release_now = rel_normal | rel_force;
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_nxt;
  logic       timeout_q;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  // A forced release only fires when nothing else is already releasing the grant
  always_comb begin
    rel_force = ~rel_normal & (hold_cnt == HoldLast);
  end

  // Hold counter restarts with every new grant and ticks once per held cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE && state_nxt == GRANT) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // Timeout pulse is visible in the first cycle after the forced release
  always_comb begin
    timeout_nxt = (state == GRANT) & rel_force;
  end

  // Register the timeout pulse alongside the other outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_nxt;
    end
  end

  assign timeout = timeout_q;
`else
  // Without the timeout feature a grant is only ever released by its owner
  always_comb begin
    rel_force = 1'b0;
  end

  assign timeout = 1'b0;
`endif

  // Next-state decision for the IDLE -> GRANT -> GAP -> IDLE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!en_n && pick_found) state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = GAP;
      GAP:     if (gap_cnt == GapLast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values; the select bus is only ever built from a single index
  always_comb begin
    gnt_n_nxt     = 16'hFFFF;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (state_nxt == GRANT) begin
          gnt_n_nxt     = ~(16'd1 << pick_idx);
          gnt_idx_nxt   = pick_idx;
          gnt_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (!release_now) begin
          gnt_n_nxt     = gnt_n;
          gnt_valid_nxt = 1'b1;
        end
      end
      default: begin
        gnt_n_nxt     = 16'hFFFF;
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_n     <= 16'hFFFF;
      gnt_idx   <= 4'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_n     <= gnt_n_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
    end
  end

  // Pointer moves past the releasing owner; gap counter times the idle gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 4'd0;
      gap_cnt <= 4'd0;
    end else begin
      case (state)
        GRANT: begin
          gap_cnt <= 4'd0;
          if (release_now) ptr <= gnt_idx + 4'd1;
        end
        GAP: begin
          if (gap_cnt == GapLast) gap_cnt <= 4'd0;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        default: gap_cnt <= 4'd0;
      endcase
    end
  end

endmodule
